demux_buf: RTL and testbench

DEMUX_BUF -- requirements
Module: demux_buf

---
 rtl/demux_buf.sv | 84 ++++++++
 tb/tb_demux_buf.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/demux_buf.sv
// One-to-four demultiplexer with a single holding register per output channel.
// Optional per-channel delivered-word counters are enabled by defining DEMUX_BUF_CNT_EN.
module demux_buf #(
    parameter int W  = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic [1:0]    in_sel,
    output logic [3:0]    out_valid,
    input  logic [3:0]    out_ready,
    output logic [W-1:0]  out_a,
    output logic [W-1:0]  out_b,
    output logic [W-1:0]  out_c,
    output logic [W-1:0]  out_d
`ifdef DEMUX_BUF_CNT_EN
    ,
    output logic [CW-1:0] cnt_a,
    output logic [CW-1:0] cnt_b,
    output logic [CW-1:0] cnt_c,
    output logic [CW-1:0] cnt_d
`endif
);

    logic [W-1:0] r_data [4];
    logic [3:0]   r_full;
    logic [3:0]   w_load;
    logic [3:0]   w_out_hs;

    // A full channel can still accept when its sink drains it in the same cycle.
    assign in_ready = ~r_full[in_sel] | out_ready[in_sel];
    assign w_load   = (in_valid && in_ready) ? (4'b0001 << in_sel) : 4'b0000;
    assign w_out_hs = r_full & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= 4'b0000;
            for (int k = 0; k < 4; k++) begin
                r_data[k] <= '0;
            end
        end else begin
            r_full <= (r_full & ~w_out_hs) | w_load;
            for (int k = 0; k < 4; k++) begin
                if (w_load[k]) begin
                    r_data[k] <= in_data;
                end
            end
        end
    end

    assign out_valid = r_full;
    assign out_a     = r_data[0];
    assign out_b     = r_data[1];
    assign out_c     = r_data[2];
    assign out_d     = r_data[3];

`ifdef DEMUX_BUF_CNT_EN
    logic [CW-1:0] r_cnt [4];

    // Counters wrap naturally at 2^CW.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (w_out_hs[k]) begin
                    r_cnt[k] <= r_cnt[k] + 1'b1;
                end
            end
        end
    end

    assign cnt_a = r_cnt[0];
    assign cnt_b = r_cnt[1];
    assign cnt_c = r_cnt[2];
    assign cnt_d = r_cnt[3];
`endif

endmodule

// File: tb/tb_demux_buf.sv
// Directed self-checking bench for demux_buf; counter checks run when DEMUX_BUF_CNT_EN is defined.
module tb_demux_buf;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic [1:0] in_sel;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [3:0] out_a, out_b, out_c, out_d;
`ifdef DEMUX_BUF_CNT_EN
    logic [7:0] cnt_a, cnt_b, cnt_c, cnt_d;
`endif

    int errors = 0;
    int checks = 0;

    demux_buf #(.W(4), .CW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_c     (out_c),
        .out_d     (out_d)
`ifdef DEMUX_BUF_CNT_EN
        ,
        .cnt_a     (cnt_a),
        .cnt_b     (cnt_b),
        .cnt_c     (cnt_c),
        .cnt_d     (cnt_d)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] pick(input int s);
        case (s)
            0:       return out_a;
            1:       return out_b;
            2:       return out_c;
            default: return out_d;
        endcase
    endfunction

    logic [3:0] route_data [4];

    initial begin
        route_data[0] = 4'h3;
        route_data[1] = 4'h5;
        route_data[2] = 4'hA;
        route_data[3] = 4'hC;

        // Reset with a word presented
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 2'd1;
        in_data   = 4'hF;
        out_ready = 4'b0000;
        tick();
        tick();
        check("rst_valid", out_valid, 4'b0000);
        check("rst_data", {out_d, out_c, out_b, out_a}, 16'h0000);
        check("rst_ready", in_ready, 1'b1);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        check("post_rst_ready", in_ready, 1'b1);

        // Back-to-back routing to all four channels
        out_ready = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_sel   = 2'(i);
            in_data  = route_data[i];
            #1;
            check($sformatf("route_ready%0d", i), in_ready, 1'b1);
            tick();
            check($sformatf("route_valid%0d", i), out_valid, 4'b0001 << i);
            check($sformatf("route_data%0d", i), pick(i), route_data[i]);
        end
        in_valid = 1'b0;
        tick();
        check("route_drain", out_valid, 4'b0000);

        // Backpressure on channel c
        out_ready = 4'b1011;
        in_valid  = 1'b1;
        in_sel    = 2'd2;
        in_data   = 4'h7;
        #1;
        check("bp_ready_first", in_ready, 1'b1);
        tick();
        check("bp_valid_c", out_valid, 4'b0100);
        check("bp_out_c7", out_c, 4'h7);
        in_data = 4'h9;
        #1;
        check("bp_ready_stall", in_ready, 1'b0);
        tick();
        check("bp_hold_c", out_c, 4'h7);
        check("bp_hold_valid", out_valid, 4'b0100);
        in_sel  = 2'd0;
        in_data = 4'h1;
        #1;
        check("bp_other_ready", in_ready, 1'b1);
        tick();
        check("bp_other_valid", out_valid, 4'b0101);
        check("bp_other_a", out_a, 4'h1);
        check("bp_still_c7", out_c, 4'h7);
        in_sel    = 2'd2;
        in_data   = 4'h9;
        out_ready = 4'b1111;
        #1;
        check("bp_pass_ready", in_ready, 1'b1);
        tick();
        check("bp_out_c9", out_c, 4'h9);
        check("bp_pass_valid", out_valid, 4'b0100);
        in_valid = 1'b0;
        tick();
        check("bp_drain", out_valid, 4'b0000);

        // Fill all channels, then reset between clock edges
        out_ready = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_sel   = 2'(i);
            in_data  = 4'(i + 8);
            tick();
        end
        in_valid = 1'b0;
        check("fill_valid", out_valid, 4'b1111);
        check("fill_data", {out_d, out_c, out_b, out_a}, 16'hBA98);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 4'b0000);
        check("async_rst_data", {out_d, out_c, out_b, out_a}, 16'h0000);
        #1;
        rst_n = 1'b1;

        // First handshake right after reset release
        in_valid = 1'b1;
        in_sel   = 2'd3;
        in_data  = 4'h6;
        tick();
        in_valid = 1'b0;
        check("first_hs_valid", out_valid, 4'b1000);
        check("first_hs_d", out_d, 4'h6);

`ifdef DEMUX_BUF_CNT_EN
        // Counter wrap on channel b
        #2;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        out_ready = 4'b1111;
        in_valid  = 1'b1;
        in_sel    = 2'd1;
        in_data   = 4'h2;
        for (int i = 0; i < 257; i++) begin
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("cnt_b_wrap", cnt_b, 8'd1);
        check("cnt_others", {cnt_a, cnt_c, cnt_d}, 24'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
